commit_trace_recorder: RTL and testbench
========================================

// Module: commit_trace_recorder
// PURPOSE
//  Synthesizable, multi-channel successor to the simulation-only commit logger. Sits beside the ROB
//  commit port in OoO_top and keeps an architectural shadow register file from commit writes. It
//  records commits into a circular trace buffer and detects end-of-program by fetch-PC wrap to 0.
//  After a fixed drain window it freezes, and the buffer is read out oldest-first on a stream port.
// PARAMETERS
//  COMMIT_W   2      commit channels per cycle; channel 0 is oldest
//  PC_W       9      fetch/commit PC width
//  DATA_W     32     register data width
//  DEPTH      64     trace entries (power of two, >= COMMIT_W)
//  POST_CYC   50     cycles still recorded after PC wrap is detected
//  TIMEOUT    10000  max cycles in ARMED and in RUN before ERROR
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  synchronous, active-high reset
//  arm           in   1                  start a capture (IDLE/DONE/ERROR only)
//  free_run      in   1                  1 = ignore PC wrap; record until stop
//  stop          in   1                  force RUN/POST -> DONE next cycle
//  fetch_pc      in   PC_W               PC presented to I-cache
//  cm_valid      in   COMMIT_W           per-channel commit valid
//  cm_pc         in   COMMIT_W*PC_W      per-channel committed PC
//  cm_we         in   COMMIT_W           per-channel architectural write enable
//  cm_rd         in   COMMIT_W*5         per-channel destination arch reg
//  cm_data       in   COMMIT_W*DATA_W    per-channel write data
//  reg_idx       in   5                  shadow-file read index
//  reg_val       out  DATA_W             shadow[reg_idx], combinational; 0 for x0
//  out_valid     out  1                  trace entry available (DONE only)
//  out_ready     in   1                  consumer accepts entry
//  out_entry     out  PC_W+1+5+DATA_W    {pc, we, rd, data} of oldest unread entry
//  state         out  3                  current FSM state encoding
//  overflowed    out  1                  sticky: an entry was overwritten this capture
//  cycle_cnt     out  32                 cycles spent in RUN+POST, saturating
//  instr_cnt     out  32                 commits recorded, saturating
// BEHAVIOUR
//  Reset: state=IDLE; shadow file, counters, wr/rd pointers, count, overflowed = 0; out_valid=0.
//  FSM: IDLE -arm-> ARMED. ARMED: on fetch_pc!=0 -> RUN; TIMEOUT cycles without that -> ERROR.
//   RUN: if !free_run and fetch_pc==0 with prev_pc!=0 -> POST (wrap needs prev_pc sampled in RUN).
//    stop -> DONE. TIMEOUT cycles in RUN without wrap -> ERROR (free_run disables this timeout).
//   POST: records POST_CYC cycles, counted from the cycle after wrap detect, then -> DONE.
//    stop -> DONE early.
//   DONE/ERROR: recording frozen; arm -> ARMED, clears buffer/counters/overflowed, keeps shadow file.
//   arm in ARMED/RUN/POST is ignored. stop in IDLE/ARMED/DONE/ERROR is ignored.
//  Recording (RUN and POST only): valid channels are compacted in channel order and written at
//   wr_ptr, wr_ptr+1, ... in the same cycle. Up to COMMIT_W writes occur per cycle.
//   count saturates at DEPTH. When the buffer is full, rd_ptr advances with wr_ptr (oldest is
//   overwritten) and overflowed sets. Pointers wrap modulo DEPTH.
//   instr_cnt += popcount(cm_valid); cycle_cnt += 1; both saturate at 2^32-1.
//  Shadow file: updated in every state except IDLE, on cm_valid & cm_we & rd!=0, visible the
//   next cycle. Same rd on several channels in one cycle: highest channel (youngest) wins.
//  Readout: out_valid = (state==DONE) && count!=0. out_entry is registered from rd_ptr.
//   A transfer occurs when out_valid & out_ready; it advances rd_ptr and decrements count with
//   1-cycle throughput. An empty buffer in DONE gives out_valid=0; the state remains DONE.
//  rst asserted in any state (including mid-drain) returns everything to reset values next edge.
// STRUCTURE
//  trace_pkg: typedef trace_entry_t {pc, we, rd, data}; typedef enum state_t
//   {IDLE, ARMED, RUN, POST, DONE, ERROR}; localparam NUM_ARCH_REGS=32.
//  Sub-module trace_ring_buffer: multi-write-port circular RAM with wr_ptr/rd_ptr/count and
//   overwrite-on-full; it also drives the output stream.
//  The top level holds the FSM, shadow file, counters and wrap detector.
// TESTING
//  1 rst; arm; fetch_pc 0 for 20 cyc then 4; 3 commits ch0 -> state RUN; instr_cnt=3.
//    Drain -> 3 entries, PCs in order.
//  2 COMMIT_W=2: both channels write rd=5 (0x11 ch0, 0x22 ch1) in one cycle -> reg_val(5)=0x22.
//    Next commit writes rd=0 with data 0xFF -> reg_val(0)=0.
//  3 fetch_pc 0x1FC -> 0x000 in RUN -> POST. Commits continue; DONE exactly 50 cyc after detect.
//    Drain returns all commits recorded in POST.
//  4 DEPTH=64, 40 cyc of 2 commits -> count=64, overflowed=1. First drained entry = commit #17.
//    out_ready toggled 1/0 -> 64 transfers, no duplicates.
//  5 arm with fetch_pc held 0 for 10000 cyc -> ERROR. arm again -> ARMED, cycle_cnt=0.
//  6 rst after 10 of 30 reads in DONE -> IDLE, out_valid=0, count=0, reg_val(any)=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace recorder: trace entry layout,
// FSM state encoding and a saturating counter helper.
package trace_pkg;

    localparam int PC_W          = 9;
    localparam int DATA_W        = 32;
    localparam int RD_W          = 5;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ENTRY_W       = PC_W + 1 + RD_W + DATA_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular trace RAM with COMMIT_W compacted write ports per cycle, overwrite-oldest
// on full, and a registered oldest-first output stream.
module trace_ring_buffer
    import trace_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        rec_en,
    input  logic [COMMIT_W-1:0]         wr_valid,
    input  trace_entry_t [COMMIT_W-1:0] wr_entry,
    input  logic                        out_en,
    input  logic                        out_ready,
    output logic                        out_valid,
    output trace_entry_t                out_entry,
    output logic                        overflowed
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0]    wr_addr [COMMIT_W];
    logic [COMMIT_W-1:0] wr_fire;
    logic [CNT_W-1:0]    n_wr;
    logic [CNT_W:0]      total;
    logic [PTR_W-1:0]    wr_ptr_nxt;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                overflow_now;
    logic                pop;
    trace_entry_t        head_nxt;

    // Stream handshake: out_valid never depends on out_ready; an entry moves on
    // every edge where out_valid && out_ready, and out_entry holds otherwise.
    assign out_valid = out_en && (count != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        n_wr    = '0;
        wr_fire = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            wr_addr[i] = wr_ptr + n_wr[PTR_W-1:0];
            wr_fire[i] = rec_en && wr_valid[i];
            if (wr_fire[i]) begin
                n_wr = n_wr + CNT_W'(1);
            end
        end

        total        = {1'b0, count} + {1'b0, n_wr};
        wr_ptr_nxt   = wr_ptr + n_wr[PTR_W-1:0];
        rd_ptr_nxt   = rd_ptr;
        overflow_now = 1'b0;
        if (total > (CNT_W+1)'(DEPTH)) begin
            // Full: the oldest entries are dropped so rd_ptr trails wr_ptr by DEPTH.
            overflow_now = 1'b1;
            rd_ptr_nxt   = rd_ptr + PTR_W'(total - (CNT_W+1)'(DEPTH));
            count_nxt    = CNT_W'(DEPTH);
        end else begin
            count_nxt    = total[CNT_W-1:0];
        end

        if (pop) begin
            rd_ptr_nxt = rd_ptr_nxt + PTR_W'(1);
            count_nxt  = count_nxt - CNT_W'(1);
        end

        // Forward same-cycle writes so the registered head is never stale.
        head_nxt = mem[rd_ptr_nxt];
        for (int i = 0; i < COMMIT_W; i++) begin
            if (wr_fire[i] && (wr_addr[i] == rd_ptr_nxt)) begin
                head_nxt = wr_entry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflowed <= 1'b0;
            out_entry  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_entry <= head_nxt;
            if (overflow_now) begin
                overflowed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (wr_fire[i]) begin
                mem[wr_addr[i]] <= wr_entry[i];
            end
        end
    end

endmodule

// File: rtl/commit_trace_recorder.sv
// Commit trace recorder: capture FSM with PC-wrap end detection, architectural
// shadow register file, RUN/POST counters and a trace ring buffer.
module commit_trace_recorder
    import trace_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 64,
    parameter int POST_CYC = 50,
    parameter int TIMEOUT  = 10000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       free_run,
    input  logic                       stop,
    input  logic [PC_W-1:0]            fetch_pc,
    input  logic [COMMIT_W-1:0]        cm_valid,
    input  logic [COMMIT_W*PC_W-1:0]   cm_pc,
    input  logic [COMMIT_W-1:0]        cm_we,
    input  logic [COMMIT_W*RD_W-1:0]   cm_rd,
    input  logic [COMMIT_W*DATA_W-1:0] cm_data,
    input  logic [RD_W-1:0]            reg_idx,
    output logic [DATA_W-1:0]          reg_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ENTRY_W-1:0]         out_entry,
    output logic [2:0]                 state,
    output logic                       overflowed,
    output logic [31:0]                cycle_cnt,
    output logic [31:0]                instr_cnt
);

    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int POST_W = $clog2(POST_CYC + 1);

    state_t                      cur_state;
    state_t                      next_state;
    logic [TMO_W-1:0]            tmo_cnt;
    logic [POST_W-1:0]           post_cnt;
    logic [PC_W-1:0]             prev_pc;
    logic                        prev_ok;
    logic                        wrap_det;
    logic                        recording;
    logic                        clear_all;
    logic [31:0]                 n_commit;
    logic [DATA_W-1:0]           shadow [NUM_ARCH_REGS];
    trace_entry_t [COMMIT_W-1:0] ch_entry;
    trace_entry_t                head;

    assign state     = cur_state;
    assign recording = (cur_state == RUN) || (cur_state == POST);
    // prev_ok is only set after a full RUN cycle, so a wrap never fires on RUN entry.
    assign wrap_det  = !free_run && prev_ok && (prev_pc != '0) && (fetch_pc == '0);
    assign reg_val   = (reg_idx == '0) ? '0 : shadow[reg_idx];
    assign out_entry = head;

    always_comb begin
        n_commit = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            ch_entry[i].pc   = cm_pc[i*PC_W +: PC_W];
            ch_entry[i].we   = cm_we[i];
            ch_entry[i].rd   = cm_rd[i*RD_W +: RD_W];
            ch_entry[i].data = cm_data[i*DATA_W +: DATA_W];
            n_commit         = n_commit + 32'(cm_valid[i]);
        end
    end

    always_comb begin
        next_state = cur_state;
        clear_all  = 1'b0;
        case (cur_state)
            IDLE, DONE, ERROR: begin
                if (arm) begin
                    next_state = ARMED;
                    clear_all  = 1'b1;
                end
            end
            ARMED: begin
                if (fetch_pc != '0) begin
                    next_state = RUN;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    next_state = ERROR;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = DONE;
                end else if (wrap_det) begin
                    next_state = POST;
                end else if (!free_run && (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
                    next_state = ERROR;
                end
            end
            POST: begin
                if (stop || (post_cnt == POST_W'(POST_CYC - 1))) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            tmo_cnt   <= '0;
            post_cnt  <= '0;
            prev_pc   <= '0;
            prev_ok   <= 1'b0;
        end else begin
            cur_state <= next_state;
            if ((next_state != cur_state) || ((cur_state == RUN) && free_run)) begin
                tmo_cnt <= '0;
            end else if ((cur_state == ARMED) || (cur_state == RUN)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            post_cnt <= (cur_state == POST) ? post_cnt + POST_W'(1) : '0;
            prev_ok  <= (cur_state == RUN);
            prev_pc  <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (recording) begin
            cycle_cnt <= sat_add32(cycle_cnt, 32'd1);
            instr_cnt <= sat_add32(instr_cnt, n_commit);
        end
    end

    // Later channels are younger, so iterating upward lets them win on equal rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                shadow[r] <= '0;
            end
        end else if (cur_state != IDLE) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (cm_valid[i] && cm_we[i] && (ch_entry[i].rd != '0)) begin
                    shadow[ch_entry[i].rd] <= ch_entry[i].data;
                end
            end
        end
    end

    trace_ring_buffer #(
        .COMMIT_W (COMMIT_W),
        .DEPTH    (DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_all),
        .rec_en     (recording),
        .wr_valid   (cm_valid),
        .wr_entry   (ch_entry),
        .out_en     (cur_state == DONE),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_entry  (head),
        .overflowed (overflowed)
    );

endmodule

// File: tb/tb_commit_trace_recorder.sv
// Directed bench for commit_trace_recorder: shadow-file vector table plus
// hand-written capture, wrap, overflow, timeout and reset sequences.
module tb_commit_trace_recorder;
    import trace_pkg::*;

    localparam int COMMIT_W = 2;
    localparam int DEPTH    = 64;
    localparam int POST_CYC = 50;
    localparam int TIMEOUT  = 10000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       arm;
    logic                       free_run;
    logic                       stop;
    logic [PC_W-1:0]            fetch_pc;
    logic [COMMIT_W-1:0]        cm_valid;
    logic [COMMIT_W*PC_W-1:0]   cm_pc;
    logic [COMMIT_W-1:0]        cm_we;
    logic [COMMIT_W*RD_W-1:0]   cm_rd;
    logic [COMMIT_W*DATA_W-1:0] cm_data;
    logic [RD_W-1:0]            reg_idx;
    logic [DATA_W-1:0]          reg_val;
    logic                       out_valid;
    logic                       out_ready;
    logic [ENTRY_W-1:0]         out_entry;
    logic [2:0]                 state;
    logic                       overflowed;
    logic [31:0]                cycle_cnt;
    logic [31:0]                instr_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [ENTRY_W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic [4:0]  idx;
        logic [31:0] exp_val;
    } sh_vec_t;

    sh_vec_t vecs[7];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    commit_trace_recorder #(
        .COMMIT_W (COMMIT_W),
        .DEPTH    (DEPTH),
        .POST_CYC (POST_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .free_run   (free_run),
        .stop       (stop),
        .fetch_pc   (fetch_pc),
        .cm_valid   (cm_valid),
        .cm_pc      (cm_pc),
        .cm_we      (cm_we),
        .cm_rd      (cm_rd),
        .cm_data    (cm_data),
        .reg_idx    (reg_idx),
        .reg_val    (reg_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_entry  (out_entry),
        .state      (state),
        .overflowed (overflowed),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp_v);
        end
    endtask

    task automatic clear_commits();
        cm_valid = '0;
        cm_we    = '0;
        cm_pc    = '0;
        cm_rd    = '0;
        cm_data  = '0;
    endtask

    task automatic drive_ch(input int ch, input logic [PC_W-1:0] pc, input logic we,
                            input logic [4:0] rd, input logic [DATA_W-1:0] data);
        cm_valid[ch]                  = 1'b1;
        cm_we[ch]                     = we;
        cm_pc[ch*PC_W +: PC_W]        = pc;
        cm_rd[ch*RD_W +: RD_W]        = rd;
        cm_data[ch*DATA_W +: DATA_W]  = data;
    endtask

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [PC_W-1:0] pc, input logic we,
                                                    input logic [4:0] rd, input logic [DATA_W-1:0] data);
        return {pc, we, rd, data};
    endfunction

    // Numbered commit n: pc=n, we=1, rd=n%31+1, data=3n
    task automatic commit_n(input int ch, input int n);
        drive_ch(ch, PC_W'(n), 1'b1, 5'(n % 31 + 1), 32'(n * 3));
    endtask

    function automatic logic [ENTRY_W-1:0] entry_n(input int n);
        return mk_entry(PC_W'(n), 1'b1, 5'(n % 31 + 1), 32'(n * 3));
    endfunction

    // ---------------- scoreboard drain ----------------
    task automatic drain(input string name, input int n, input bit toggle);
        int got;
        int guard;
        bit rdy;
        got   = 0;
        guard = 0;
        rdy   = 1'b1;
        while ((got < n) && (guard < 400)) begin
            out_ready = toggle ? rdy : 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra"}, 64'(out_entry), 64'(0));
                end else begin
                    check({name, "_entry"}, 64'(out_entry), 64'(exp_q.pop_front()));
                end
                got++;
            end
            tick();
            guard++;
            rdy = !rdy;
        end
        out_ready = 1'b0;
        check({name, "_count"}, 64'(got), 64'(n));
        check({name, "_empty"}, 64'(out_valid), 64'(0));
        check({name, "_state"}, 64'(state), 64'(S_DONE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int post_cycles;

        vecs[0] = '{valid: 2'b11, we: 2'b11, rd0: 5'd5,  d0: 32'h11,   rd1: 5'd5,  d1: 32'h22,       idx: 5'd5,  exp_val: 32'h22};
        vecs[1] = '{valid: 2'b01, we: 2'b01, rd0: 5'd0,  d0: 32'hFF,   rd1: 5'd0,  d1: 32'h0,        idx: 5'd0,  exp_val: 32'h0};
        vecs[2] = '{valid: 2'b11, we: 2'b01, rd0: 5'd7,  d0: 32'hA5A5, rd1: 5'd7,  d1: 32'hDEAD,     idx: 5'd7,  exp_val: 32'hA5A5};
        vecs[3] = '{valid: 2'b10, we: 2'b11, rd0: 5'd9,  d0: 32'h99,   rd1: 5'd9,  d1: 32'h77,       idx: 5'd9,  exp_val: 32'h77};
        vecs[4] = '{valid: 2'b00, we: 2'b11, rd0: 5'd5,  d0: 32'h33,   rd1: 5'd5,  d1: 32'h33,       idx: 5'd5,  exp_val: 32'h22};
        vecs[5] = '{valid: 2'b11, we: 2'b11, rd0: 5'd1,  d0: 32'h1,    rd1: 5'd31, d1: 32'hCAFEF00D, idx: 5'd31, exp_val: 32'hCAFEF00D};
        vecs[6] = '{valid: 2'b00, we: 2'b00, rd0: 5'd0,  d0: 32'h0,    rd1: 5'd0,  d1: 32'h0,        idx: 5'd1,  exp_val: 32'h1};

        rst       = 1'b1;
        arm       = 1'b0;
        free_run  = 1'b0;
        stop      = 1'b0;
        fetch_pc  = '0;
        out_ready = 1'b0;
        reg_idx   = '0;
        clear_commits();
        tick();
        tick();
        rst = 1'b0;

        check("reset_state",      64'(state),      64'(S_IDLE));
        check("reset_out_valid",  64'(out_valid),  64'(0));
        check("reset_overflowed", 64'(overflowed), 64'(0));
        check("reset_cycle_cnt",  64'(cycle_cnt),  64'(0));
        check("reset_instr_cnt",  64'(instr_cnt),  64'(0));

        // T1: arm, hold fetch_pc 0, start, three ch0 commits, stop, drain
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t1_armed", 64'(state), 64'(S_ARMED));
        repeat (20) tick();
        check("t1_still_armed", 64'(state), 64'(S_ARMED));
        fetch_pc = 9'd4;
        tick();
        check("t1_run", 64'(state), 64'(S_RUN));
        for (int i = 0; i < 3; i++) begin
            clear_commits();
            drive_ch(0, 9'(9'h10 + i), 1'b1, 5'(i + 1), 32'(32'h100 + i));
            exp_q.push_back(mk_entry(9'(9'h10 + i), 1'b1, 5'(i + 1), 32'(32'h100 + i)));
            tick();
        end
        clear_commits();
        check("t1_instr_cnt", 64'(instr_cnt), 64'(3));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t1_done", 64'(state), 64'(S_DONE));
        check("t1_cycle_cnt", 64'(cycle_cnt), 64'(4));
        check("t1_out_valid", 64'(out_valid), 64'(1));
        drain("t1", 3, 1'b0);

        // T2: shadow file vectors applied while DONE (recording frozen)
        for (int v = 0; v < 7; v++) begin
            clear_commits();
            for (int ch = 0; ch < 2; ch++) begin
                if (vecs[v].we[ch] || vecs[v].valid[ch]) begin
                    drive_ch(ch, 9'h0, vecs[v].we[ch], (ch == 0) ? vecs[v].rd0 : vecs[v].rd1,
                             (ch == 0) ? vecs[v].d0 : vecs[v].d1);
                    cm_valid[ch] = vecs[v].valid[ch];
                end
            end
            tick();
            clear_commits();
            reg_idx = vecs[v].idx;
            #1;
            check($sformatf("t2_vec%0d_reg_val", v), 64'(reg_val), 64'(vecs[v].exp_val));
        end
        check("t2_frozen_valid", 64'(out_valid), 64'(0));
        check("t2_frozen_instr", 64'(instr_cnt), 64'(3));

        // T3: PC wrap 0x1FC -> 0 ends RUN, POST records exactly POST_CYC cycles
        arm      = 1'b1;
        fetch_pc = 9'h1FC;
        tick();
        arm = 1'b0;
        check("t3_armed", 64'(state), 64'(S_ARMED));
        tick();
        check("t3_run", 64'(state), 64'(S_RUN));
        tick();
        fetch_pc = 9'h000;
        tick();
        check("t3_post", 64'(state), 64'(S_POST));
        post_cycles = 0;
        for (int g = 0; g < 100; g++) begin
            if (state != S_POST) break;
            clear_commits();
            drive_ch(0, 9'(9'h40 + post_cycles), 1'b0, 5'd0, 32'(post_cycles));
            exp_q.push_back(mk_entry(9'(9'h40 + post_cycles), 1'b0, 5'd0, 32'(post_cycles)));
            post_cycles++;
            tick();
        end
        clear_commits();
        check("t3_post_cycles", 64'(post_cycles), 64'(POST_CYC));
        check("t3_done", 64'(state), 64'(S_DONE));
        check("t3_instr_cnt", 64'(instr_cnt), 64'(50));
        check("t3_cycle_cnt", 64'(cycle_cnt), 64'(52));
        check("t3_no_overflow", 64'(overflowed), 64'(0));
        drain("t3", 50, 1'b0);

        // T4: free-run overflow, 80 commits into 64 entries, toggled ready
        arm      = 1'b1;
        free_run = 1'b1;
        fetch_pc = 9'd4;
        tick();
        arm = 1'b0;
        tick();
        check("t4_run", 64'(state), 64'(S_RUN));
        for (int c = 0; c < 40; c++) begin
            clear_commits();
            commit_n(0, 2 * c + 1);
            commit_n(1, 2 * c + 2);
            if (c == 20) fetch_pc = 9'd0;
            if (c == 25) fetch_pc = 9'd4;
            tick();
        end
        clear_commits();
        check("t4_free_run_no_wrap", 64'(state), 64'(S_RUN));
        stop = 1'b1;
        tick();
        stop     = 1'b0;
        free_run = 1'b0;
        check("t4_done", 64'(state), 64'(S_DONE));
        check("t4_overflowed", 64'(overflowed), 64'(1));
        check("t4_instr_cnt", 64'(instr_cnt), 64'(80));
        check("t4_cycle_cnt", 64'(cycle_cnt), 64'(41));
        check("t4_first_is_17", 64'(out_entry), 64'(entry_n(17)));
        for (int n = 17; n <= 80; n++) exp_q.push_back(entry_n(n));
        drain("t4", 64, 1'b1);

        // T5: ARMED timeout with fetch_pc stuck at 0, then re-arm clears counters
        fetch_pc = 9'd0;
        arm      = 1'b1;
        tick();
        arm = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("t5_armed_before_timeout", 64'(state), 64'(S_ARMED));
        tick();
        check("t5_error", 64'(state), 64'(S_ERROR));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_stop_ignored", 64'(state), 64'(S_ERROR));
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_rearmed", 64'(state), 64'(S_ARMED));
        check("t5_cycle_cnt", 64'(cycle_cnt), 64'(0));
        check("t5_instr_cnt", 64'(instr_cnt), 64'(0));
        check("t5_overflowed", 64'(overflowed), 64'(0));

        // T6: reset in the middle of a drain
        fetch_pc = 9'd4;
        tick();
        check("t6_run", 64'(state), 64'(S_RUN));
        for (int c = 0; c < 15; c++) begin
            clear_commits();
            commit_n(0, 2 * c + 1);
            commit_n(1, 2 * c + 2);
            exp_q.push_back(entry_n(2 * c + 1));
            exp_q.push_back(entry_n(2 * c + 2));
            arm = (c == 5);
            tick();
        end
        arm = 1'b0;
        clear_commits();
        check("t6_arm_ignored", 64'(state), 64'(S_RUN));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6_done", 64'(state), 64'(S_DONE));
        out_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            check("t6_partial_valid", 64'(out_valid), 64'(1));
            check("t6_partial_entry", 64'(out_entry), 64'(exp_q.pop_front()));
            tick();
        end
        out_ready = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_idle", 64'(state), 64'(S_IDLE));
        check("t6_out_valid", 64'(out_valid), 64'(0));
        check("t6_overflowed", 64'(overflowed), 64'(0));
        check("t6_instr_cnt", 64'(instr_cnt), 64'(0));
        check("t6_cycle_cnt", 64'(cycle_cnt), 64'(0));
        foreach (vecs[v]) begin
            reg_idx = vecs[v].idx;
            #1;
            check($sformatf("t6_reg_val_r%0d", vecs[v].idx), 64'(reg_val), 64'(0));
        end
        // IDLE does not update the shadow file
        drive_ch(0, 9'h0, 1'b1, 5'd5, 32'h55);
        tick();
        clear_commits();
        reg_idx = 5'd5;
        #1;
        check("t6_idle_no_shadow", 64'(reg_val), 64'(0));
        // Empty capture after reset: DONE with nothing to stream
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        check("t6_rerun", 64'(state), 64'(S_RUN));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t6_empty_done", 64'(state), 64'(S_DONE));
        check("t6_empty_valid", 64'(out_valid), 64'(0));
        tick();
        check("t6_empty_stays_done", 64'(state), 64'(S_DONE));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
